// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the datapath and the seven-segment scan controller:
// digit data and control going in, registered pin drives coming out.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic [7:0]                seg_n;
  logic [NUM_DIGITS-1:0]     dig_n;
  logic                      frame_start;
  logic                      pending;

  modport master (
    output enable, load, data_in, dp_in, blank_in,
    input  seg_n, dig_n, frame_start, pending
  );

  modport slave (
    input  enable, load, data_in, dp_in, blank_in,
    output seg_n, dig_n, frame_start, pending
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// New digit data is double-buffered and only applied at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [7:0]              r_seg_n;
  logic [NUM_DIGITS-1:0]   r_dig_n;
  logic                    r_frame_start;

  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic [3:0]              w_nibble;
  logic                    w_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_dig_sel;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

  assign w_slot_end = (r_state == S_DRIVE) && (r_cnt == SLOT_LAST);
  assign w_wrap     = bus.enable && w_slot_end && (r_idx == IDX_LAST);

  // Pick the current digit's nibble/flags and its active-low enable pattern.
  always_comb begin
    w_nibble  = '0;
    w_dp      = 1'b0;
    w_blank   = 1'b0;
    w_dig_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nibble     = r_act_data[4*k +: 4];
        w_dp         = r_act_dp[k];
        w_blank      = r_act_blank[k];
        w_dig_sel[k] = 1'b0;
      end
    end
  end

  // A load landing on the wrap edge goes to the pending buffer and keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else begin
      if (w_wrap && r_pending) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
      end
      if (bus.load) begin
        r_pend_data  <= bus.data_in;
        r_pend_dp    <= bus.dp_in;
        r_pend_blank <= bus.blank_in;
        r_pending    <= 1'b1;
      end else if (w_wrap) begin
        r_pending    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_seg_n       <= 8'hFF;
      r_dig_n       <= '1;
      r_frame_start <= 1'b0;
    end else if (!bus.enable) begin
      r_seg_n       <= 8'hFF;
      r_dig_n       <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= (r_state == S_BLANK) && (r_idx == '0) && (r_cnt == '0);
      case (r_state)
        S_BLANK: begin
          r_seg_n <= 8'hFF;
          r_dig_n <= '1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == BLANK_LAST) begin
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (w_blank) begin
            r_seg_n <= 8'hFF;
            r_dig_n <= '1;
          end else begin
            r_seg_n <= {~w_dp, hex2seg(w_nibble)};
            r_dig_n <= w_dig_sel;
          end
          if (w_slot_end) begin
            r_cnt   <= '0;
            r_state <= S_BLANK;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_BLANK;
        end
      endcase
    end
  end

  assign bus.seg_n       = r_seg_n;
  assign bus.dig_n       = r_dig_n;
  assign bus.frame_start = r_frame_start;
  assign bus.pending     = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int S     = 10;
  localparam int B     = 2;
  localparam int FRAME = N * S;

  logic clk;
  logic rst_n;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) ifc ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the display position is just the count of enabled cycles modulo the frame.
  int          pos;
  logic [15:0] mPendData, mActData;
  logic [3:0]  mPendDp, mActDp, mPendBlank, mActBlank;
  bit          mPending;
  logic [7:0]  expSeg;
  logic [3:0]  expDig;
  bit          expFs;

  always @(posedge clk or negedge rst_n) begin
    int p, d, o;
    if (!rst_n) begin
      pos = 0;
      mPendData = '0; mActData = '0;
      mPendDp = '0; mActDp = '0; mPendBlank = '0; mActBlank = '0;
      mPending = 1'b0;
      expSeg = 8'hFF; expDig = 4'hF; expFs = 1'b0;
    end else begin
      if (!ifc.enable) begin
        expSeg = 8'hFF; expDig = 4'hF; expFs = 1'b0;
      end else begin
        p = pos % FRAME;
        d = p / S;
        o = p % S;
        expFs = (p == 0);
        if (o < B || mActBlank[d]) begin
          expSeg = 8'hFF; expDig = 4'hF;
        end else begin
          expDig = 4'hF;
          expDig[d] = 1'b0;
          expSeg = {~mActDp[d], segTable[mActData[4*d +: 4]]};
        end
        if (p == FRAME - 1 && mPending) begin
          mActData = mPendData; mActDp = mPendDp; mActBlank = mPendBlank;
          mPending = 1'b0;
        end
        pos++;
      end
      if (ifc.load) begin
        mPendData = ifc.data_in; mPendDp = ifc.dp_in; mPendBlank = ifc.blank_in;
        mPending = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_seg", ifc.seg_n, expSeg);
      checkOutput("model_dig", ifc.dig_n, expDig);
      checkOutput("model_fs", ifc.frame_start, expFs);
      checkOutput("model_pend", ifc.pending, mPending);
    end
  end

  // All tasks start and finish just after a falling edge.
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank);
    ifc.data_in  = data;
    ifc.dp_in    = dp;
    ifc.blank_in = blank;
    ifc.load     = 1'b1;
    @(negedge clk);
    ifc.load     = 1'b0;
  endtask

  task automatic waitFrame(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if (ifc.frame_start) found = 1'b1;
    end
    checkOutput({tag, "_frame_seen"}, found, 1);
  endtask

  task automatic waitDigit(input int d, input logic [7:0] want, input string tag);
    logic [3:0] target;
    bit found = 1'b0;
    target = 4'hF;
    target[d] = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if (ifc.dig_n == target) found = 1'b1;
    end
    checkOutput({tag, "_seen"}, found, 1);
    if (found) checkOutput(tag, ifc.seg_n, want);
  endtask

  int fsCount, firstFs, periodFs, cnt88, dig1Cycles, dig2Seen, darkCount;
  bit found1;

  initial begin
    rst_n = 1'b0;
    ifc.enable = 1'b0; ifc.load = 1'b0;
    ifc.data_in = '0; ifc.dp_in = '0; ifc.blank_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_seg", ifc.seg_n, 8'hFF);
    checkOutput("rst_dig", ifc.dig_n, 4'hF);
    checkOutput("rst_fs", ifc.frame_start, 0);
    checkOutput("rst_pend", ifc.pending, 0);
    checkEn = 1'b1;
    rst_n = 1'b1;
    ifc.enable = 1'b1;

    // frame_start cadence right after reset release
    fsCount = 0; firstFs = -1; periodFs = -1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (ifc.frame_start) begin
        fsCount++;
        if (firstFs < 0) firstFs = i;
        else if (periodFs < 0) periodFs = i - firstFs;
      end
    end
    checkOutput("fs_first", firstFs, 1);
    checkOutput("fs_count", fsCount, 2);
    checkOutput("fs_period", periodFs, FRAME);

    applyStimulus(16'h0000, 4'h0, 4'h0);
    waitDigit(0, 8'hC0, "zero_dig0");

    // mid-frame load of 0x1234 with dp on digit 0
    repeat (3) @(negedge clk);
    applyStimulus(16'h1234, 4'b0001, 4'b0000);
    checkOutput("pend_set", ifc.pending, 1);
    waitFrame("l1234");
    checkOutput("pend_clr", ifc.pending, 0);
    waitDigit(0, 8'h19, "l1234_dig0");
    waitDigit(1, 8'hB0, "l1234_dig1");
    waitDigit(2, 8'hA4, "l1234_dig2");
    waitDigit(3, 8'hF9, "l1234_dig3");

    for (int h = 0; h < 16; h++) begin
      logic [3:0] nib;
      nib = 4'(h);
      waitFrame("sweep_sync");
      applyStimulus({4{nib}}, 4'h0, 4'h0);
      waitFrame("sweep");
      waitDigit(0, {1'b1, segTable[h]}, $sformatf("sweep_%0h", h));
    end

    // double load inside one frame: only the last value may ever show
    waitFrame("dbl_sync");
    applyStimulus(16'hAAAA, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    applyStimulus(16'hFFFF, 4'h0, 4'h0);
    waitFrame("dbl");
    for (int d = 0; d < N; d++) waitDigit(d, 8'h8E, $sformatf("dbl_dig%0d", d));
    cnt88 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (ifc.seg_n == 8'h88) cnt88++;
    end
    checkOutput("dbl_no_A", cnt88, 0);

    // digit 2 blanked, enable dropped for 15 cycles in the middle of digit 1's drive
    waitFrame("blk_sync");
    applyStimulus(16'h9876, 4'b0110, 4'b0100);
    waitFrame("blk");
    dig1Cycles = 0; dig2Seen = 0; darkCount = 0; found1 = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found1; i++) begin
      @(negedge clk);
      if (ifc.dig_n == 4'b1101) found1 = 1'b1;
    end
    checkOutput("blk_dig1_seen", found1, 1);
    dig1Cycles = found1 ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.dig_n == 4'b1101) dig1Cycles++;
    end
    ifc.enable = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ifc.dig_n == 4'b1101) dig1Cycles++;
      if (ifc.dig_n == 4'hF && ifc.seg_n == 8'hFF && !ifc.frame_start) darkCount++;
    end
    ifc.enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (ifc.dig_n == 4'b1101 && i < S) dig1Cycles++;
      if (ifc.dig_n == 4'b1011) dig2Seen++;
    end
    checkOutput("blk_dig1_cycles", dig1Cycles, S - B);
    checkOutput("blk_dark_while_off", darkCount, 15);
    checkOutput("blk_dig2_never", dig2Seen, 0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      ifc.enable   = ($urandom_range(0, 9) != 0);
      ifc.load     = ($urandom_range(0, 7) == 0);
      ifc.data_in  = 16'($urandom);
      ifc.dp_in    = 4'($urandom);
      ifc.blank_in = 4'($urandom);
      @(negedge clk);
    end
    ifc.enable = 1'b1;
    ifc.load   = 1'b0;

    // asynchronous reset during digit 2 drive with data pending
    waitFrame("rst_sync");
    applyStimulus(16'h5678, 4'h0, 4'h0);
    waitFrame("rst");
    waitDigit(2, {1'b1, segTable[6]}, "rst_dig2");
    applyStimulus(16'h9999, 4'h0, 4'h0);
    checkOutput("rst_pend_before", ifc.pending, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_seg", ifc.seg_n, 8'hFF);
    checkOutput("async_dig", ifc.dig_n, 4'hF);
    checkOutput("async_fs", ifc.frame_start, 0);
    checkOutput("async_pend", ifc.pending, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitDigit(0, 8'hC0, "post_rst_dig0");
    repeat (FRAME) @(negedge clk);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It drives NUM_DIGITS digits through one shared, active-low segment bus. It holds a double-buffered copy of the digit values and applies new values only at frame boundaries, so a display never shows a mix of old and new data. It converts each 4-bit hex nibble to segment codes internally and inserts a blanking gap between digits to suppress ghosting. It sits between the datapath (counters, result registers) and the board's segment and digit-enable pins.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- SLOT_CYCLES, 50000: clk cycles per digit slot (at least BLANK_CYCLES+1).
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off (at least 1).
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan; 0 = all digits off, scan counters held.
- load  in  1  one-cycle strobe; captures data_in/dp_in/blank_in into pending buffer.
- data_in  in  4*NUM_DIGITS  hex nibbles; digit k = data_in[4k+3:4k], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit dark regardless of data.
- seg_n  out  8  active-low segments; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- dig_n  out  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.
- pending  out  1  1 = loaded data not yet applied.

## Operation
- Decode (hex to seg_n[6:0], active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. dp lit gives seg_n[7]=0.
- Buffers: pending_reg and active_reg.
  - load=1 writes pending_reg and sets pending.
  - A second load before transfer overwrites pending_reg. Last value wins.
- Transfer: at every frame boundary (slot counter wraps from digit NUM_DIGITS-1 to digit 0), if pending=1 then active_reg <= pending_reg and pending clears.
  - If load and a transfer occur in the same cycle, the load data goes to pending_reg and pending stays 1.
  - The transferred value is the value held in pending_reg before that edge.
- FSM, per slot:
  - BLANK: BLANK_CYCLES cycles. dig_n all 1, seg_n=FF.
  - DRIVE: SLOT_CYCLES-BLANK_CYCLES cycles. dig_n[idx]=0, seg_n = decode(active_reg[idx]).
  - DRIVE end: idx increments, wrapping from NUM_DIGITS-1 to 0, and the FSM returns to BLANK.
- A blanked digit still consumes its slot. dig_n stays all 1 and seg_n=FF for the whole slot.
- enable=0:
  - Next cycle: dig_n all 1, seg_n=FF.
  - Slot counter, idx, and FSM state hold. No transfer, no frame_start.
  - Loads are still accepted.
  - On re-enable, scanning resumes from the held state.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: seg_n=FF, dig_n all 1, frame_start=0, pending=0, pending_reg=0, active_reg=0, idx=0, state=BLANK, slot counter=0.
- After rst_n rises, the first frame_start asserts at the 1st rising edge. Digit 0 DRIVE begins BLANK_CYCLES cycles later.
- Frame period: NUM_DIGITS*SLOT_CYCLES cycles. frame_start is high for exactly one cycle per frame.
- Load-to-display latency: from pending set to the next frame boundary, then BLANK_CYCLES more before digit 0 shows the new data.
  - Worst case is NUM_DIGITS*SLOT_CYCLES + BLANK_CYCLES cycles.
- Reset asserted mid-scan forces all reset values immediately (asynchronous); no partial frame is completed.

## Test plan
- Reset, with NUM_DIGITS=4, SLOT_CYCLES=10, BLANK_CYCLES=2:
  - After release: dig_n=1111, seg_n=FF, frame_start pulses once per 40 cycles.
  - Digit 0 DRIVE shows seg_n=C0 (0 with dp off) after load 0x0000.
- Load data_in=0x1234 with dp_in=0001, mid-frame:
  - pending=1 until the next frame boundary.
  - Next frame shows: dig0 seg_n=19 (dp on), dig1=30, dig2=24, dig3=79, each for 8 cycles after a 2-cycle blank.
- Decode sweep: all 16 nibbles on digit 0 match the code list, with dp off giving seg_n[7]=1.
- Double load within one frame: 0xAAAA then 0xFFFF. Only 0xFFFF appears (seg_n=8E on every digit); 0xAAAA is never displayed.
- blank_in=0100 with enable toggled to 0 for 15 cycles mid-DRIVE:
  - Digit 2 is never driven.
  - While enable=0, outputs are dark and the counters are frozen.
  - On re-enable, scanning resumes on the same digit with the remaining cycle count.
- Assert rst_n low during digit 2 DRIVE with pending=1: next cycle all outputs equal their reset values and pending=0.
